// File: rtl/shift_acc_if.sv
// Beat/result handshake bundle for the bit-serial shift accumulator.
// master drives beats and consumes results; slave is the accumulator.
interface shift_acc_if #(
    parameter int ACC_W = 24
);
    logic                         start;
    logic                         in_valid;
    logic                         in_ready;
    logic [7:0][3:0][15:0]        result_engine;
    logic [7:0][2:0]              shift_out;
    logic                         out_valid;
    logic                         out_ready;
    logic [7:0][3:0][ACC_W-1:0]   out_data;
    logic                         err_shift;

    modport master (
        output start, in_valid, result_engine, shift_out, out_ready,
        input  in_ready, out_valid, out_data, err_shift
    );

    modport slave (
        input  start, in_valid, result_engine, shift_out, out_ready,
        output in_ready, out_valid, out_data, err_shift
    );
endinterface

// File: rtl/shift_acc_unit.sv
// Bit-slice shift accumulator: 32 lanes, one weight slice per beat.
// Define SHIFT_ACC_SIGNED_MSB_EN to subtract the top slice (signed weights).
module shift_acc_unit #(
    parameter int ACC_W   = 24,
    parameter int N_SLICE = 5
) (
    input logic        clk,
    input logic        rst_n,
    shift_acc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [2:0] LAST = 3'(N_SLICE - 1);

    typedef logic [7:0][3:0][ACC_W-1:0] lanes_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       cnt;
    lanes_t           acc;
    lanes_t           sum;
    logic [ACC_W-1:0] term;
    logic             fire;
    logic             last;
    logic             mism;

    assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !bus.start;
    assign fire         = bus.in_valid && bus.in_ready;
    assign last         = (cnt == LAST);

    // Per-lane next accumulator value; slice weight comes from cnt only.
    always_comb begin
        sum  = acc;
        term = '0;
        for (int e = 0; e < 8; e++) begin
            for (int l = 0; l < 4; l++) begin
                term = {{(ACC_W-16){bus.result_engine[e][l][15]}},
                        bus.result_engine[e][l]} << cnt;
`ifdef SHIFT_ACC_SIGNED_MSB_EN
                if (last)
                    sum[e][l] = acc[e][l] - term;
                else
                    sum[e][l] = acc[e][l] + term;
`else
                sum[e][l] = acc[e][l] + term;
`endif
            end
        end
    end

    // Any engine reporting a slice index other than cnt is a mismatch.
    always_comb begin
        mism = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (bus.shift_out[j] != cnt)
                mism = 1'b1;
        end
    end

    // Slice counter, accumulators and sticky mismatch flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            acc           <= '0;
            bus.err_shift <= 1'b0;
        end else if (bus.start) begin
            cnt           <= '0;
            acc           <= '0;
            bus.err_shift <= 1'b0;
        end else if (fire) begin
            if (mism)
                bus.err_shift <= 1'b1;
            if (last) begin
                cnt <= '0;
                acc <= '0;
            end else begin
                cnt <= cnt + 3'd1;
                acc <= sum;
            end
        end
    end

    // Output register: loads on group completion, held until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (fire && last) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sum;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    // Group-tracking state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Group-tracking next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fire && last)
                    state_d = bus.out_ready ? IDLE : HOLD;
                else if (fire)
                    state_d = ACC;
            end
            ACC: begin
                if (bus.start)
                    state_d = IDLE;
                else if (fire && last)
                    state_d = bus.out_ready ? IDLE : HOLD;
            end
            HOLD: begin
                if (bus.out_ready)
                    state_d = fire ? ACC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/shift_acc_unit.md
SHIFT_ACC_UNIT -- requirements
Module: shift_acc_unit

Interface
REQ-001 The block SHALL expose parameter ACC_W, default 24, meaning the signed accumulator width per lane.
REQ-002 The block SHALL expose parameter N_SLICE, default 5, meaning the number of weight bit-slices per group, valid range 2..8.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  synchronous group restart: clears the slice counter and all accumulators.
REQ-006 in_valid  input  1  a partial-product beat is present.
REQ-007 in_ready  output  1  the block can accept a beat.
REQ-008 result_engine  input  [7:0][3:0][15:0]  32 signed 16-bit partial products (engine, lane).
REQ-009 shift_out  input  [7:0][2:0]  per-engine bit-slice index of the beat.
REQ-010 out_valid  output  1  out_data holds a completed group.
REQ-011 out_ready  input  1  the consumer accepts out_data.
REQ-012 out_data  output  [7:0][3:0][ACC_W-1:0]  32 signed accumulated dot products.
REQ-013 err_shift  output  1  sticky flag: a slice-index mismatch was detected.

Function
REQ-014 in_ready SHALL equal (!out_valid || out_ready) && !start.
REQ-015 A beat SHALL be accepted only when in_valid && in_ready are both high in the same cycle.
REQ-016 A 3-bit slice counter cnt SHALL be 0 after reset or start, increment on each accepted beat, and wrap from N_SLICE-1 to 0.
REQ-017 Per lane, each accepted beat SHALL form term = sign_extend(result_engine, ACC_W) << cnt; shift_out SHALL NOT be used as the shift amount.
REQ-018 For a beat with cnt < N_SLICE-1, each lane SHALL update acc <= acc + term (modulo 2^ACC_W, no saturation).
REQ-019 For a beat with cnt == N_SLICE-1, each lane SHALL write acc + term (or acc - term per REQ-028) to out_data, clear acc to 0, and set out_valid the next cycle; latency from the last beat to out_valid is 1 cycle.
REQ-020 out_valid SHALL clear when out_ready is high and no new group completes in the same cycle.
REQ-021 A group completing while out_valid && out_ready are both high SHALL overwrite out_data, and out_valid SHALL stay 1.
REQ-022 out_data SHALL remain stable while out_valid && !out_ready.
REQ-023 On an accepted beat, err_shift SHALL set if any shift_out[j] != cnt; it SHALL clear only on reset or start.
REQ-024 start SHALL clear cnt, acc and err_shift, and SHALL NOT alter out_valid or out_data; no beat is accepted in a start cycle.
REQ-025 The FSM SHALL have three states. IDLE (cnt==0, acc==0) -> ACC on an accepted beat. ACC -> IDLE on the last slice or on start. IDLE/ACC -> HOLD when a group completes while the output is blocked. HOLD -> IDLE on out_ready.

Reset
REQ-026 On rst_n low, the block SHALL drive out_valid=0, out_data=0, err_shift=0, cnt=0 and all acc=0, with FSM in IDLE.
REQ-027 A reset asserted mid-group SHALL discard all partial accumulation; in_ready SHALL be 1 on the first cycle after release.

Configuration
REQ-028 With macro SHIFT_ACC_SIGNED_MSB_EN defined, the slice with cnt == N_SLICE-1 SHALL be subtracted (two's-complement weights); without it, every slice SHALL be added (unsigned weights).

Verification
REQ-029 Unsigned build: all lanes = 1 on 5 back-to-back beats, shift_out = 0..4 -> out_data = 31 in every lane, out_valid 1 cycle after beat 5.
REQ-030 SHIFT_ACC_SIGNED_MSB_EN build: same stimulus as REQ-029 -> every lane = -1 (0xFFFFFF).
REQ-031 Lane values = -32768 on all 5 slices, unsigned build -> out_data = -1015808 (0xF08000); no saturation.
REQ-032 out_ready held low after a completed group -> in_ready = 0 and out_data stable for 10 cycles; raise out_ready -> handshake completes and accumulation resumes.
REQ-033 shift_out[3] = 2 on slice 1 -> err_shift = 1 and result still uses cnt; start -> err_shift = 0, cnt = 0.
REQ-034 rst_n asserted after 3 beats, then 5 beats of value 2 -> out_data = 62 (unsigned build), with no residue from the aborted group.
